adc_packetizer: RTL and testbench

Framing stage between the four per-channel byte buffers (widthConverter outputs) and `udp_tx_top`, all on the 125 MHz domain. When the buffers signal a complete capture, it drains channels 1, 2, 4 and 8 in order, wrapping each fixed-size payload in a header and trailer. It emits one contiguous byte-per-cycle frame per packet on the `udp_tx_valid`/`udp_tx_data` interface. It replaces the bare round-robin read path, so the host can identify channel, order, length and integrity of every packet.

---
 rtl/adc_packetizer_if.sv | 10 +
 rtl/adc_packetizer.sv | 179 +++++++++++++++++
 tb/tb_adc_packetizer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_packetizer_if.sv
// Byte-stream link from the packetizer to udp_tx_top: one frame byte per cycle,
// with the MAC's busy flag gating the start of each frame.
interface adc_packetizer_if;
    logic       udp_tx_valid;
    logic [7:0] udp_tx_data;
    logic       udp_tx_busy;

    modport master (output udp_tx_valid, output udp_tx_data, input udp_tx_busy);
    modport slave  (input udp_tx_valid, input udp_tx_data, output udp_tx_busy);
endinterface

// File: rtl/adc_packetizer.sv
// Drains the four capture buffers in channel order (1, 2, 4, 8) and wraps each
// fixed-size payload in an 8-byte header and a status/XOR trailer for udp_tx_top.
module adc_packetizer #(
    parameter int unsigned PAYLOAD_BYTES = 1024,
    parameter logic [15:0] MAGIC         = 16'hADC0,
    parameter int unsigned GAP_CYCLES    = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             dump,
    input  logic [3:0]       empty,
    input  logic [7:0]       din0,
    input  logic [7:0]       din1,
    input  logic [7:0]       din2,
    input  logic [7:0]       din3,
    output logic [3:0]       rd_en,
    adc_packetizer_if.master udp,
    output logic             active,
    output logic             done
);

    localparam logic [15:0] PLEN  = 16'(PAYLOAD_BYTES);
    localparam logic [15:0] PLAST = 16'(PAYLOAD_BYTES - 1);
    localparam logic [15:0] GLAST = 16'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT_BUSY,
        S_HEADER,
        S_PAYLOAD,
        S_TRAILER,
        S_GAP
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt;
    logic [1:0]  ch;
    logic [15:0] seq;
    logic [7:0]  csum;
    logic        underrun;
    logic        skip;
    logic        dump_q;
    logic        tx_valid;
    logic [7:0]  tx_data;

    logic        dump_rise;
    logic        ch_empty;
    logic        read_due;
    logic [7:0]  hdr_byte;
    logic [7:0]  din_sel;
    logic [7:0]  pay_byte;

    assign dump_rise        = dump & ~dump_q;
    assign ch_empty         = empty[ch];
    assign pay_byte         = skip ? 8'h00 : din_sel;
    assign udp.udp_tx_valid = tx_valid;
    assign udp.udp_tx_data  = tx_data;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_n  = state;
        read_due = 1'b0;
        rd_en    = 4'b0000;
        case (state)
            S_IDLE:      if (dump_rise) state_n = S_SELECT;
            S_SELECT: begin
                if (!ch_empty)          state_n = S_WAIT_BUSY;
                else if (ch == 2'd3)    state_n = S_IDLE;
            end
            S_WAIT_BUSY: if (!udp.udp_tx_busy) state_n = S_HEADER;
            S_HEADER: begin
                if (cnt == 16'd7) begin
                    state_n  = S_PAYLOAD;
                    read_due = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (cnt == PLAST) state_n  = S_TRAILER;
                else              read_due = 1'b1;
            end
            S_TRAILER:   if (cnt == 16'd1) state_n = S_GAP;
            S_GAP:       if (cnt == GLAST) state_n = S_SELECT;
            default:     state_n = S_IDLE;
        endcase
        // Reads run one byte ahead of the output register; an empty buffer means a pad byte.
        if (read_due && !ch_empty) rd_en[ch] = 1'b1;
    end

    always_comb begin
        hdr_byte = 8'h00;
        case (cnt[2:0])
            3'd0:    hdr_byte = MAGIC[15:8];
            3'd1:    hdr_byte = MAGIC[7:0];
            3'd2:    hdr_byte = seq[15:8];
            3'd3:    hdr_byte = seq[7:0];
            3'd4:    hdr_byte = 8'h01 << ch;
            3'd5:    hdr_byte = 8'h00;
            3'd6:    hdr_byte = PLEN[15:8];
            default: hdr_byte = PLEN[7:0];
        endcase
    end

    always_comb begin
        din_sel = din0;
        case (ch)
            2'd1:    din_sel = din1;
            2'd2:    din_sel = din2;
            2'd3:    din_sel = din3;
            default: din_sel = din0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= 16'd0;
            ch       <= 2'd0;
            seq      <= 16'd0;
            csum     <= 8'h00;
            underrun <= 1'b0;
            skip     <= 1'b0;
            dump_q   <= 1'b1;  // a level held through reset is not a new capture
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            active   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= (state_n != state) ? 16'd0 : cnt + 16'd1;
            dump_q   <= dump;
            done     <= 1'b0;
            skip     <= read_due & ch_empty;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            case (state)
                S_IDLE: begin
                    if (dump_rise) begin
                        active <= 1'b1;
                        ch     <= 2'd0;
                    end
                end
                S_SELECT: begin
                    if (ch_empty) begin
                        ch <= ch + 2'd1;
                        if (ch == 2'd3) begin
                            done   <= 1'b1;
                            active <= 1'b0;
                        end
                    end
                end
                S_HEADER: begin
                    tx_valid <= 1'b1;
                    tx_data  <= hdr_byte;
                end
                S_PAYLOAD: begin
                    tx_valid <= 1'b1;
                    tx_data  <= pay_byte;
                    csum     <= csum ^ pay_byte;
                    if (skip) underrun <= 1'b1;
                end
                S_TRAILER: begin
                    tx_valid <= 1'b1;
                    if (cnt == 16'd0) begin
                        tx_data <= {6'b000000, ch_empty, underrun};
                    end else begin
                        tx_data  <= csum;
                        csum     <= 8'h00;
                        underrun <= 1'b0;
                        seq      <= seq + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_packetizer.sv
// Self-checking bench for adc_packetizer: buffer model feeding the DUT, frame
// monitor, and a chunk-and-pad reference model of the expected byte stream.
module tb_adc_packetizer;

    localparam int          P     = 1024;
    localparam int          GAP   = 12;
    localparam logic [15:0] MAGIC = 16'hADC0;
    localparam logic [15:0] PLEN  = 16'(P);

    typedef enum logic [1:0] {K_COUNT, K_A5} kind_t;

    typedef struct packed {
        logic [3:0][15:0] len;
        kind_t            kind;
        logic [15:0]      busy_cycles;
        logic             redump;
        logic [7:0]       exp_frames;
        logic [7:0]       exp_chan0;
        logic [15:0]      exp_trl;
    } vec_t;

    logic       clk;
    logic       rstn;
    logic       dump;
    logic       busy;
    logic [3:0] empty;
    logic [7:0] din [4];
    logic [3:0] rd_en;
    logic       active;
    logic       done;
    logic       udp_valid;
    logic [7:0] udp_data;

    adc_packetizer_if udp_if ();
    assign udp_if.udp_tx_busy = busy;
    assign udp_valid          = udp_if.udp_tx_valid;
    assign udp_data           = udp_if.udp_tx_data;

    adc_packetizer #(.PAYLOAD_BYTES(P), .MAGIC(MAGIC), .GAP_CYCLES(GAP)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .dump   (dump),
        .empty  (empty),
        .din0   (din[0]),
        .din1   (din[1]),
        .din2   (din[2]),
        .din3   (din[3]),
        .rd_en  (rd_en),
        .udp    (udp_if),
        .active (active),
        .done   (done)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Buffer model: fixed contents per channel, read one byte per rd_en.
    logic [7:0] mem [4][4096];
    int         fill_len [4];
    int         len_q [4];
    int         rptr [4];
    int         rd_total [4];
    int         rd_bad;
    int         rd_multi;
    logic       fill_go;

    always @(posedge clk) begin
        if ($countones(rd_en) > 1) rd_multi <= rd_multi + 1;
        for (int i = 0; i < 4; i++) begin
            if (fill_go) begin
                rptr[i]  <= 0;
                len_q[i] <= fill_len[i];
            end else if (rd_en[i]) begin
                if (rptr[i] < len_q[i]) din[i] <= mem[i][rptr[i]];
                else                    rd_bad <= rd_bad + 1;
                rptr[i]     <= rptr[i] + 1;
                rd_total[i] <= rd_total[i] + 1;
            end
        end
    end

    always_comb begin
        empty = 4'b0000;
        for (int i = 0; i < 4; i++) empty[i] = (rptr[i] >= len_q[i]);
    end

    // Frame monitor: a frame is a maximal run of valid cycles.
    logic [7:0] got_bytes [$];
    int         got_lens [$];
    int         got_start [$];
    int         got_end [$];
    int         cur_len;
    int         cyc;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (udp_valid) begin
            got_bytes.push_back(udp_data);
            if (cur_len == 0) got_start.push_back(cyc);
            cur_len <= cur_len + 1;
        end else if (cur_len != 0) begin
            got_lens.push_back(cur_len);
            got_end.push_back(cyc - 1);
            cur_len <= 0;
        end
    end

    logic [7:0]  exp_bytes [$];
    int          exp_lens [$];
    logic [15:0] m_seq;
    int          n_vec;
    int          n_miss;
    vec_t        vecs [6];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    function automatic vec_t mk(input int l0, input int l1, input int l2, input int l3,
                                input kind_t kind, input int busy_cycles, input bit redump,
                                input int frames, input logic [7:0] chan0, input logic [15:0] trl);
        vec_t v;
        v.len[0]      = 16'(l0);
        v.len[1]      = 16'(l1);
        v.len[2]      = 16'(l2);
        v.len[3]      = 16'(l3);
        v.kind        = kind;
        v.busy_cycles = 16'(busy_cycles);
        v.redump      = redump;
        v.exp_frames  = 8'(frames);
        v.exp_chan0   = chan0;
        v.exp_trl     = trl;
        return v;
    endfunction

    task automatic load_bufs(input vec_t v, input bit rnd);
        for (int c = 0; c < 4; c++) begin
            fill_len[c] = int'(v.len[c]);
            for (int i = 0; i < fill_len[c]; i++)
                mem[c][i] = rnd ? 8'($urandom) : (v.kind == K_A5 ? 8'hA5 : 8'(i));
        end
        fill_go = 1'b1;
        tick(1);
        fill_go = 1'b0;
    endtask

    // Reference: cut each channel into P-byte chunks, zero-pad the tail, append status and XOR.
    task automatic model_dump();
        logic [7:0] x;
        logic [7:0] b;
        logic       und;
        for (int c = 0; c < 4; c++) begin
            for (int pos = 0; pos < fill_len[c]; pos += P) begin
                x   = 8'h00;
                und = 1'b0;
                exp_bytes.push_back(MAGIC[15:8]);
                exp_bytes.push_back(MAGIC[7:0]);
                exp_bytes.push_back(m_seq[15:8]);
                exp_bytes.push_back(m_seq[7:0]);
                exp_bytes.push_back(8'(1 << c));
                exp_bytes.push_back(8'h00);
                exp_bytes.push_back(PLEN[15:8]);
                exp_bytes.push_back(PLEN[7:0]);
                for (int k = 0; k < P; k++) begin
                    if (pos + k < fill_len[c]) b = mem[c][pos + k];
                    else begin
                        b   = 8'h00;
                        und = 1'b1;
                    end
                    x = x ^ b;
                    exp_bytes.push_back(b);
                end
                exp_bytes.push_back({6'b000000, pos + P >= fill_len[c], und});
                exp_bytes.push_back(x);
                exp_lens.push_back(P + 10);
                m_seq = m_seq + 16'd1;
            end
        end
    endtask

    task automatic run_entry(input int id, input vec_t v, input bit rnd);
        int gf0, gb0, ef0, eb0, n, found, ngot, nexp, nf, g, e, gl, el, m, idx, min_idle, idle;
        int rd0 [4];
        gf0 = got_lens.size();
        gb0 = got_bytes.size();
        ef0 = exp_lens.size();
        eb0 = exp_bytes.size();
        for (int c = 0; c < 4; c++) rd0[c] = rd_total[c];
        load_bufs(v, rnd);
        model_dump();

        dump = 1'b1;
        busy = (v.busy_cycles != 16'd0);
        tick(1);
        check($sformatf("v%0d active_rise", id), active, 1);
        check($sformatf("v%0d no_early_valid", id), udp_valid, 0);
        dump = 1'b0;
        if (v.busy_cycles != 16'd0) begin
            n = 0;
            repeat (int'(v.busy_cycles) - 1) begin
                tick(1);
                if (udp_valid) n++;
            end
            check($sformatf("v%0d valid_while_busy", id), n, 0);
            busy = 1'b0;
            n = 0;
            while (!udp_valid && n < 8) begin
                tick(1);
                n++;
            end
            check($sformatf("v%0d start_after_busy_le2", id), n <= 2, 1);
        end

        found = 0;
        n = 0;
        while (!found && n < 12000) begin
            if (rnd) busy = ($urandom_range(0, 3) == 0);
            dump = (v.redump && n == 300);
            tick(1);
            n++;
            if (done) found = 1;
        end
        busy = 1'b0;
        dump = 1'b0;
        check($sformatf("v%0d done_seen", id), found, 1);
        check($sformatf("v%0d active_fall", id), active, 0);
        tick(1);
        check($sformatf("v%0d done_one_cycle", id), done, 0);
        tick(4);
        check($sformatf("v%0d stays_idle", id), active, 0);

        ngot = got_lens.size() - gf0;
        nexp = exp_lens.size() - ef0;
        check($sformatf("v%0d frame_count_model", id), ngot, nexp);
        if (!rnd) check($sformatf("v%0d frame_count", id), ngot, int'(v.exp_frames));
        for (int c = 0; c < 4; c++)
            check($sformatf("v%0d rd_count_ch%0d", id, c), rd_total[c] - rd0[c], int'(v.len[c]));

        nf = (ngot < nexp) ? ngot : nexp;
        g = gb0;
        e = eb0;
        min_idle = 1 << 30;
        for (int f = 0; f < nf; f++) begin
            gl = got_lens[gf0 + f];
            el = exp_lens[ef0 + f];
            check($sformatf("v%0d f%0d length", id, f), gl, el);
            m = (gl < el) ? gl : el;
            idx = m - 1;
            for (int i = 0; i < m; i++) begin
                if (got_bytes[g + i] !== exp_bytes[e + i]) begin
                    idx = i;
                    break;
                end
            end
            check($sformatf("v%0d f%0d byte%0d", id, f, idx), got_bytes[g + idx], exp_bytes[e + idx]);
            if (!rnd && f == 0) begin
                check($sformatf("v%0d magic", id), {got_bytes[g], got_bytes[g + 1]}, 32'hADC0);
                check($sformatf("v%0d chan0", id), got_bytes[g + 4], v.exp_chan0);
            end
            if (!rnd && f == nf - 1)
                check($sformatf("v%0d last_trailer", id), {got_bytes[g + gl - 2], got_bytes[g + gl - 1]},
                      v.exp_trl);
            if (f > 0) begin
                idle = got_start[gf0 + f] - got_end[gf0 + f - 1] - 1;
                if (idle < min_idle) min_idle = idle;
            end
            g += gl;
            e += el;
        end
        if (nf > 1) check($sformatf("v%0d min_gap_ok", id), min_idle >= GAP, 1);
    endtask

    initial begin
        int base, gf0;
        vec_t rv;
        n_vec    = 0;
        n_miss   = 0;
        m_seq    = 16'd0;
        rd_bad   = 0;
        rd_multi = 0;
        fill_go  = 1'b0;
        for (int c = 0; c < 4; c++) fill_len[c] = 0;

        vecs[0] = mk(1024, 0, 0, 0, K_COUNT, 0, 0, 1, 8'h01, 16'h0200);
        vecs[1] = mk(2048, 2048, 2048, 2048, K_COUNT, 0, 0, 8, 8'h01, 16'h0200);
        vecs[2] = mk(0, 1000, 0, 0, K_A5, 0, 0, 1, 8'h02, 16'h0300);
        vecs[3] = mk(0, 0, 1024, 0, K_COUNT, 200, 1, 1, 8'h04, 16'h0200);
        vecs[4] = mk(0, 0, 0, 1031, K_A5, 0, 0, 2, 8'h08, 16'h03A5);
        vecs[5] = mk(0, 0, 0, 0, K_COUNT, 0, 0, 0, 8'h00, 16'h0000);

        rstn = 1'b0;
        dump = 1'b1;
        busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("reset_outputs_c%0d", i), {udp_valid, udp_data, rd_en, active, done}, 0);
        end
        dump = 1'b0;
        rstn = 1'b1;
        tick(2);
        check("post_reset_idle", {udp_valid, udp_data, rd_en, active, done}, 0);

        for (int i = 0; i < 6; i++) run_entry(i, vecs[i], 1'b0);

        for (int r = 0; r < 3; r++) begin
            rv = mk($urandom_range(0, 1500), $urandom_range(0, 1500), $urandom_range(0, 1500),
                    $urandom_range(0, 1500), K_COUNT, 0, 0, 0, 8'h00, 16'h0000);
            run_entry(10 + r, rv, 1'b1);
        end

        // Reset in the middle of a payload truncates the frame and restarts seq.
        gf0 = got_lens.size();
        load_bufs(vecs[0], 1'b0);
        dump = 1'b1;
        tick(1);
        dump = 1'b0;
        for (int n = 0; n < 3000 && cur_len < 308; n++) tick(1);
        check("midreset_reached_payload", cur_len >= 308, 1);
        rstn = 1'b0;
        tick(1);
        check("midreset_valid_drop", udp_valid, 0);
        check("midreset_active_clear", active, 0);
        rstn = 1'b1;
        m_seq = 16'd0;
        tick(3);
        check("midreset_one_partial", got_lens.size() - gf0, 1);
        if (got_lens.size() > gf0)
            check("midreset_truncated", got_lens[got_lens.size() - 1] < P + 10, 1);
        base = got_bytes.size();
        run_entry(20, vecs[0], 1'b0);
        if (got_bytes.size() > base + 4)
            check("midreset_seq_zero", {got_bytes[base + 2], got_bytes[base + 3]}, 0);

        check("rd_en_on_empty", rd_bad, 0);
        check("rd_en_onehot", rd_multi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
